// File: rtl/wt_cache_pkg.sv
// Shared write-through dcache types and constants used by the replacement-update path.
package wt_cache_pkg;

  localparam int unsigned DCACHE_SET_ASSOC       = 4;
  localparam int unsigned DCACHE_CL_IDX_WIDTH    = 8;
  localparam int unsigned DCACHE_WAY_WIDTH       = $clog2(DCACHE_SET_ASSOC);
  localparam int unsigned DCACHE_REPL_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [DCACHE_CL_IDX_WIDTH-1:0] idx;
    logic [DCACHE_WAY_WIDTH-1:0]    way;
    logic                           vld;
  } repl_upd_t;

endpackage

// File: rtl/wt_dcache_repl_fifo.sv
// Pending-hit queue: several pushes per cycle, one pop, and a purge that invalidates
// every entry matching a line that is being replaced.
module wt_dcache_repl_fifo
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumPorts  = 3,
  parameter int unsigned FifoDepth = DCACHE_REPL_FIFO_DEPTH
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    flush_i,
  input  logic [NumPorts-1:0]                     push,
  input  logic [NumPorts*DCACHE_CL_IDX_WIDTH-1:0] push_idx,
  input  logic [NumPorts*DCACHE_WAY_WIDTH-1:0]    push_way,
  input  logic                                    pop,
  input  logic                                    purge,
  input  logic [DCACHE_CL_IDX_WIDTH-1:0]          purge_idx,
  input  logic [DCACHE_WAY_WIDTH-1:0]             purge_way,
  output logic [DCACHE_CL_IDX_WIDTH-1:0]          head_idx,
  output logic [DCACHE_WAY_WIDTH-1:0]             head_way,
  output logic                                    head_vld,
  output logic [DCACHE_CL_IDX_WIDTH-1:0]          tail_idx,
  output logic [DCACHE_WAY_WIDTH-1:0]             tail_way,
  output logic                                    tail_vld,
  output logic [$clog2(FifoDepth):0]              cnt
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned IdxW = DCACHE_CL_IDX_WIDTH;
  localparam int unsigned WayW = DCACHE_WAY_WIDTH;

  logic [IdxW-1:0]      idx_q [FifoDepth];
  logic [WayW-1:0]      way_q [FifoDepth];
  logic [FifoDepth-1:0] vld_q;
  logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q, tail_ptr;
  logic [PtrW:0]        cnt_q, n_push;
  logic [PtrW-1:0]      wr_addr [NumPorts];

  // Accepted pushes are packed into consecutive slots in port order.
  always_comb begin
    n_push = '0;
    for (int p = 0; p < NumPorts; p++) begin
      wr_addr[p] = wr_ptr_q + n_push[PtrW-1:0];
      if (push[p]) n_push = n_push + (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PtrW'(pop);
      wr_ptr_q <= wr_ptr_q + n_push[PtrW-1:0];
      cnt_q    <= cnt_q + n_push - (PtrW+1)'(pop);
      for (int i = 0; i < FifoDepth; i++) begin
        if (purge && vld_q[i] && idx_q[i] == purge_idx && way_q[i] == purge_way)
          vld_q[i] <= 1'b0;
      end
      for (int p = 0; p < NumPorts; p++) begin
        if (push[p]) vld_q[wr_addr[p]] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NumPorts; p++) begin
      if (push[p]) begin
        idx_q[wr_addr[p]] <= push_idx[p*IdxW +: IdxW];
        way_q[wr_addr[p]] <= push_way[p*WayW +: WayW];
      end
    end
  end

  assign tail_ptr = wr_ptr_q - PtrW'(1);
  assign head_idx = idx_q[rd_ptr_q];
  assign head_way = way_q[rd_ptr_q];
  assign head_vld = vld_q[rd_ptr_q] & (cnt_q != '0);
  assign tail_idx = idx_q[tail_ptr];
  assign tail_way = way_q[tail_ptr];
  assign tail_vld = vld_q[tail_ptr] & (cnt_q != '0);
  assign cnt      = cnt_q;

endmodule

// File: rtl/wt_dcache_repl_upd.sv
// Serialises dcache hit events into single NRU update strobes; refill misses take
// priority and bypass the queue combinationally.
module wt_dcache_repl_upd
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumPorts  = 3,
  parameter int unsigned FifoDepth = DCACHE_REPL_FIFO_DEPTH
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    flush_i,
  input  logic [NumPorts-1:0]                     hit_req_i,
  input  logic [NumPorts*DCACHE_CL_IDX_WIDTH-1:0] hit_idx_i,
  input  logic [NumPorts*DCACHE_WAY_WIDTH-1:0]    hit_way_i,
  input  logic                                    miss_req_i,
  input  logic [DCACHE_CL_IDX_WIDTH-1:0]          miss_idx_i,
  output logic [DCACHE_WAY_WIDTH-1:0]             victim_way_o,
  output logic                                    nru_hit_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0]          nru_hit_idx_o,
  output logic [DCACHE_WAY_WIDTH-1:0]             nru_hit_way_o,
  output logic                                    nru_miss_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0]          nru_miss_idx_o,
  input  logic [DCACHE_WAY_WIDTH-1:0]             nru_way_i,
  output logic                                    fifo_empty_o,
  output logic [15:0]                             drop_cnt_o
);

  localparam int unsigned IdxW  = DCACHE_CL_IDX_WIDTH;
  localparam int unsigned WayW  = DCACHE_WAY_WIDTH;
  localparam int unsigned CntW  = $clog2(FifoDepth) + 1;
  localparam int unsigned DropW = $clog2(NumPorts + 1);

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [DropW-1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + 17'(b);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [NumPorts-1:0] push;
  logic [CntW-1:0]     cnt, free;
  logic [DropW-1:0]    n_drop;
  logic                pop, dup, stale;
  logic [IdxW-1:0]     cur_idx, head_idx, tail_idx;
  logic [WayW-1:0]     cur_way, head_way, tail_way;
  logic                head_vld, tail_vld;
  logic [15:0]         drop_cnt_q;

  assign nru_miss_o     = miss_req_i;
  assign nru_miss_idx_o = miss_idx_i;
  assign victim_way_o   = nru_way_i;

  assign fifo_empty_o  = (cnt == '0);
  assign pop           = !miss_req_i && !flush_i && !fifo_empty_o;
  assign nru_hit_o     = pop && head_vld;
  assign nru_hit_idx_o = head_idx;
  assign nru_hit_way_o = head_way;
  assign drop_cnt_o    = drop_cnt_q;

  // Duplicates and hits on the line being evicted vanish silently; only overflow counts.
  always_comb begin
    push    = '0;
    n_drop  = '0;
    dup     = 1'b0;
    stale   = 1'b0;
    cur_idx = '0;
    cur_way = '0;
    free    = CntW'(FifoDepth) - cnt + CntW'(pop);
    for (int p = 0; p < NumPorts; p++) begin
      cur_idx = hit_idx_i[p*IdxW +: IdxW];
      cur_way = hit_way_i[p*WayW +: WayW];
      dup     = tail_vld && cur_idx == tail_idx && cur_way == tail_way;
      for (int q = 0; q < p; q++) begin
        if (hit_req_i[q] && hit_idx_i[q*IdxW +: IdxW] == cur_idx &&
            hit_way_i[q*WayW +: WayW] == cur_way)
          dup = 1'b1;
      end
      stale = miss_req_i && cur_idx == miss_idx_i && cur_way == nru_way_i;
      if (hit_req_i[p] && !flush_i && !dup && !stale) begin
        if (free != '0) begin
          push[p] = 1'b1;
          free    = free - CntW'(1);
        end else begin
          n_drop = n_drop + DropW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)             drop_cnt_q <= '0;
    else if (n_drop != '0)   drop_cnt_q <= sat_add(drop_cnt_q, n_drop);
  end

  wt_dcache_repl_fifo #(
    .NumPorts  (NumPorts),
    .FifoDepth (FifoDepth)
  ) i_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (flush_i),
    .push      (push),
    .push_idx  (hit_idx_i),
    .push_way  (hit_way_i),
    .pop       (pop),
    .purge     (miss_req_i),
    .purge_idx (miss_idx_i),
    .purge_way (nru_way_i),
    .head_idx  (head_idx),
    .head_way  (head_way),
    .head_vld  (head_vld),
    .tail_idx  (tail_idx),
    .tail_way  (tail_way),
    .tail_vld  (tail_vld),
    .cnt       (cnt)
  );

endmodule
